// File: rtl/branch_target_buffer_pkg.sv
// Shared constants and counter encoding for the branch target buffer.
package branch_target_buffer_pkg;

  localparam int unsigned BTB_ENTRIES = 8;
  localparam int unsigned BTB_XLEN    = 32;

  typedef enum logic [1:0] {
    BTB_CNT_SNT = 2'b00,
    BTB_CNT_WNT = 2'b01,
    BTB_CNT_WT  = 2'b10,
    BTB_CNT_ST  = 2'b11
  } btb_cnt_e;

  // Fresh allocations start weakly taken so one not-taken outcome flips them.
  localparam btb_cnt_e BTB_CNT_ALLOC = BTB_CNT_WT;
  localparam btb_cnt_e BTB_CNT_RESET = BTB_CNT_WNT;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch lookup, resolver update and perf-counter signals of the BTB.
interface branch_target_buffer_if;

  logic [31:0] fetch_pc;
  logic        predicted_taken;
  logic [31:0] predicted_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic        update_taken;
  logic        update_mispredict;
  logic [31:0] lookup_hits;
  logic [31:0] mispredicts;

  modport master (
    output fetch_pc, update_en, update_pc, update_target, update_taken, update_mispredict,
    input  predicted_taken, predicted_target, lookup_hits, mispredicts
  );

  modport slave (
    input  fetch_pc, update_en, update_pc, update_target, update_taken, update_mispredict,
    output predicted_taken, predicted_target, lookup_hits, mispredicts
  );

endinterface

// File: rtl/branch_target_buffer_sat_counter2.sv
// 2-bit saturating up/down counter step; passes cur through when en=0.
module sat_counter2
  import branch_target_buffer_pkg::*;
(
  input  logic     en,
  input  logic     taken,
  input  btb_cnt_e cur,
  output btb_cnt_e nxt
);

  always_comb begin
    nxt = cur;
    if (en) begin
      unique case (cur)
        BTB_CNT_SNT: nxt = taken ? BTB_CNT_WNT : BTB_CNT_SNT;
        BTB_CNT_WNT: nxt = taken ? BTB_CNT_WT  : BTB_CNT_SNT;
        BTB_CNT_WT:  nxt = taken ? BTB_CNT_ST  : BTB_CNT_WNT;
        BTB_CNT_ST:  nxt = taken ? BTB_CNT_ST  : BTB_CNT_WT;
        default:     nxt = cur;
      endcase
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit counters, combinational
// fetch lookup, edge-applied resolver training and perf counters.
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int unsigned ENTRIES = BTB_ENTRIES,
  parameter int unsigned IDX_W   = $clog2(ENTRIES),
  parameter int unsigned TAG_W   = 32 - IDX_W - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_target_buffer_if.slave bus
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  logic [31:0]        tgt_d [ENTRIES];
  btb_cnt_e           cnt_q [ENTRIES];
  btb_cnt_e           cnt_d [ENTRIES];
  logic [31:0]        lookup_hits_q, lookup_hits_d;
  logic [31:0]        mispredicts_q, mispredicts_d;

  logic [IDX_W-1:0]   f_idx, u_idx;
  logic [TAG_W-1:0]   f_tag, u_tag;
  logic               f_hit, u_hit;
  btb_cnt_e           cnt_nxt;
  logic               unused_pc_lsbs;

  assign f_idx = bus.fetch_pc[IDX_W+1:2];
  assign f_tag = bus.fetch_pc[31:IDX_W+2];
  assign u_idx = bus.update_pc[IDX_W+1:2];
  assign u_tag = bus.update_pc[31:IDX_W+2];
  assign unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.update_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign bus.predicted_taken  = f_hit && cnt_q[f_idx][1];
  assign bus.predicted_target = f_hit ? tgt_q[f_idx] : '0;
  assign bus.lookup_hits      = lookup_hits_q;
  assign bus.mispredicts      = mispredicts_q;

  sat_counter2 u_sat_counter2 (
    .en    (bus.update_en && u_hit),
    .taken (bus.update_taken),
    .cur   (cnt_q[u_idx]),
    .nxt   (cnt_nxt)
  );

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (bus.update_en) begin
      if (u_hit) begin
        cnt_d[u_idx] = cnt_nxt;
        if (bus.update_taken) tgt_d[u_idx] = bus.update_target;
      end else if (bus.update_taken) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = bus.update_target;
        cnt_d[u_idx]   = BTB_CNT_ALLOC;
      end
    end
    lookup_hits_d = lookup_hits_q + 32'(f_hit);
    mispredicts_d = mispredicts_q + 32'(bus.update_en && bus.update_mispredict);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      tag_q         <= '{default: '0};
      tgt_q         <= '{default: '0};
      cnt_q         <= '{default: BTB_CNT_RESET};
      lookup_hits_q <= '0;
      mispredicts_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      cnt_q         <= cnt_d;
      lookup_hits_q <= lookup_hits_d;
      mispredicts_q <= mispredicts_d;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed scoreboard bench for branch_target_buffer (ENTRIES=8).
module tb_branch_target_buffer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_target_buffer_if bus();

  branch_target_buffer #(.ENTRIES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned exp_hits = 0;
  int unsigned exp_mis  = 0;

  localparam logic [31:0] IDLE_PC = 32'hFFFF_FFFC;

  task automatic expect_v(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", e.name, obs, e.val);
    end
  endtask

  task automatic lookup(input string n, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_target);
    bus.fetch_pc = pc;
    expect_v({n, "_taken"}, {31'b0, exp_taken});
    expect_v({n, "_target"}, exp_target);
    #1;
    observe({31'b0, bus.predicted_taken});
    observe(bus.predicted_target);
    bus.fetch_pc = IDLE_PC;
  endtask

  task automatic check_perf(input string n);
    expect_v({n, "_lookup_hits"}, exp_hits);
    expect_v({n, "_mispredicts"}, exp_mis);
    #1;
    observe(bus.lookup_hits);
    observe(bus.mispredicts);
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic taken, input logic mis);
    bus.update_en         = 1'b1;
    bus.update_pc         = pc;
    bus.update_target     = tgt;
    bus.update_taken      = taken;
    bus.update_mispredict = mis;
    if (mis) exp_mis++;
    @(posedge clk); #1;
    bus.update_en         = 1'b0;
    bus.update_mispredict = 1'b0;
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n                 = 1'b0;
    bus.fetch_pc          = IDLE_PC;
    bus.update_en         = 1'b0;
    bus.update_pc         = '0;
    bus.update_target     = '0;
    bus.update_taken      = 1'b0;
    bus.update_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lookup("reset", 32'h100, 1'b0, 32'h0);
    check_perf("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Allocate, then one hit cycle.
    update(32'h100, 32'h200, 1'b1, 1'b0);
    lookup("alloc", 32'h100, 1'b1, 32'h200);
    bus.fetch_pc = 32'h100;
    @(posedge clk); #1;
    bus.fetch_pc = IDLE_PC;
    exp_hits++;
    check_perf("alloc");

    // 10 -> 11 (saturates), then step down; not-taken updates must not move the target.
    repeat (3) update(32'h100, 32'h200, 1'b1, 1'b0);
    update(32'h100, 32'hDEAD_BEEC, 1'b0, 1'b0);
    lookup("sat_st_to_wt", 32'h100, 1'b1, 32'h200);
    update(32'h100, 32'hDEAD_BEEC, 1'b0, 1'b0);
    lookup("sat_wnt", 32'h100, 1'b0, 32'h200);
    repeat (2) update(32'h100, 32'hDEAD_BEEC, 1'b0, 1'b0);
    update(32'h100, 32'h244, 1'b1, 1'b0);
    lookup("sat_snt_held", 32'h100, 1'b0, 32'h244);
    update(32'h100, 32'h244, 1'b1, 1'b0);
    lookup("sat_back_wt", 32'h100, 1'b1, 32'h244);

    // Aliasing on index 0.
    update(32'h120, 32'h480, 1'b1, 1'b0);
    lookup("alias_old", 32'h100, 1'b0, 32'h0);
    lookup("alias_new", 32'h120, 1'b1, 32'h480);

    // Miss with not-taken, and update_en low, allocate nothing.
    update(32'h300, 32'h600, 1'b0, 1'b0);
    lookup("miss_nt", 32'h300, 1'b0, 32'h0);
    lookup("miss_nt_keep", 32'h120, 1'b1, 32'h480);
    bus.update_pc     = 32'h104;
    bus.update_target = 32'h999;
    bus.update_taken  = 1'b1;
    bus.update_mispredict = 1'b1;
    @(posedge clk); #1;
    bus.update_mispredict = 1'b0;
    lookup("upd_disabled", 32'h104, 1'b0, 32'h0);

    // Stalled repeats count every hit cycle.
    bus.fetch_pc = 32'h120;
    repeat (3) @(posedge clk);
    #1;
    bus.fetch_pc = IDLE_PC;
    exp_hits += 3;
    check_perf("stall_hits");

    // Same-cycle lookup/allocate returns old contents.
    bus.fetch_pc      = 32'h140;
    bus.update_en     = 1'b1;
    bus.update_pc     = 32'h140;
    bus.update_target = 32'h700;
    bus.update_taken  = 1'b1;
    expect_v("collide_now_taken", 32'h0);
    #1;
    observe({31'b0, bus.predicted_taken});
    @(posedge clk); #1;
    bus.update_en = 1'b0;
    expect_v("collide_next_taken", 32'h1);
    expect_v("collide_next_target", 32'h700);
    observe({31'b0, bus.predicted_taken});
    observe(bus.predicted_target);
    @(posedge clk); #1;
    bus.fetch_pc = IDLE_PC;
    exp_hits++;
    check_perf("collide");

    repeat (5) update(32'h300, 32'h0, 1'b0, 1'b1);
    check_perf("mispredict");

    // Asynchronous reset mid-cycle with an update in flight.
    bus.fetch_pc      = 32'h140;
    bus.update_en     = 1'b1;
    bus.update_pc     = 32'h180;
    bus.update_target = 32'h900;
    bus.update_taken  = 1'b1;
    bus.update_mispredict = 1'b1;
    #1;
    rst_n = 1'b0;
    exp_hits = 0;
    exp_mis  = 0;
    lookup("rst_mid", 32'h140, 1'b0, 32'h0);
    check_perf("rst_mid");
    @(posedge clk); #1;
    bus.update_en = 1'b0;
    bus.update_mispredict = 1'b0;
    rst_n = 1'b1;
    lookup("rst_dropped_upd", 32'h180, 1'b0, 32'h0);
    lookup("rst_cleared", 32'h140, 1'b0, 32'h0);
    check_perf("rst_after");

    update(32'h140, 32'h800, 1'b1, 1'b0);
    lookup("realloc", 32'h140, 1'b1, 32'h800);
    update(32'h140, 32'h0, 1'b0, 1'b0);
    lookup("realloc_nt", 32'h140, 1'b0, 32'h800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
